// File: rtl/vec_accel.sv
// Vector accelerator: A/B operand banks, RES_NUM accumulator lanes, one element per cycle.
// Optional feature macro VEC_ACCEL_SAT_EN: unsigned saturation of f results and accumulations.
module vec_accel #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int RES_NUM = 4,
  parameter int ADDR_W  = 12
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              ack_o,
  output logic              resp_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              irq_o
);

  localparam int WW = ADDR_W - 2;
  localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (RES_NUM > 1) ? $clog2(RES_NUM) : 1;
  localparam logic [WW-1:0] B_BASE = WW'(DEPTH);
  localparam logic [WW-1:0] R_BASE = WW'(2 * DEPTH);
  localparam logic [WW-1:0] C_WORD = WW'(2 * DEPTH + RES_NUM);
  localparam logic [WW-1:0] S_WORD = WW'(2 * DEPTH + RES_NUM + 1);
  localparam logic [DW-1:0] LAST   = DW'(DEPTH - 1);
  localparam logic [XLEN-1:0] XMAX = '1;
`ifdef VEC_ACCEL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [XLEN-1:0]   a_q   [DEPTH];
  logic [XLEN-1:0]   b_q   [DEPTH];
  logic [XLEN-1:0]   res_q [RES_NUM];
  logic [1:0]        mode_q;
  logic              done_q;
  logic              err_q;
  logic [DW-1:0]     idx_q;
  logic              resp_q;
  logic [XLEN-1:0]   rdata_q;

  logic [WW-1:0]     word;
  logic [DW-1:0]     abi;
  logic [RW-1:0]     resi;
  logic              hit_a, hit_b, hit_res, hit_ctrl, hit_stat;
  logic              busy, wr, rd, start_acc, err_set;
  logic              unused_addr;

  assign word     = addr_i[ADDR_W-1:2];
  assign abi      = word[DW-1:0];
  assign resi     = word[RW-1:0];
  assign hit_a    = (word < B_BASE);
  assign hit_b    = (word >= B_BASE) && (word < R_BASE);
  assign hit_res  = (word >= R_BASE) && (word < C_WORD);
  assign hit_ctrl = (word == C_WORD);
  assign hit_stat = (word == S_WORD);
  assign unused_addr = &{1'b0, addr_i[1:0]};

  assign busy      = (state_q == RUN);
  assign wr        = req_i & we_i;
  assign rd        = req_i & ~we_i;
  assign start_acc = wr & hit_ctrl & wdata_i[0] & ~busy;
  // Errors: start while busy, operand write while busy, write to anything but A/B/CTRL.
  assign err_set   = (wr & hit_ctrl & wdata_i[0] & busy)
                   | (wr & (hit_a | hit_b) & busy)
                   | (wr & ~(hit_a | hit_b | hit_ctrl));

  logic [XLEN-1:0]   op_a, op_b, f_val, lane_val, acc_val;
  logic [XLEN:0]     op_sum, acc_sum;
  logic [2*XLEN-1:0] op_prod;
  logic [RW-1:0]     lane;

  assign op_a    = a_q[idx_q];
  assign op_b    = b_q[idx_q];
  assign lane    = idx_q[RW-1:0];
  assign op_sum  = {1'b0, op_a} + {1'b0, op_b};
  assign op_prod = {{XLEN{1'b0}}, op_a} * {{XLEN{1'b0}}, op_b};

  always_comb begin
    f_val = '0;
    case (mode_q)
      2'd0:    f_val = (SAT && op_sum[XLEN]) ? XMAX : op_sum[XLEN-1:0];
      2'd1:    f_val = (SAT && (|op_prod[2*XLEN-1:XLEN])) ? XMAX : op_prod[XLEN-1:0];
      2'd2:    f_val = (op_a >= op_b) ? op_a : op_b;
      default: f_val = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
    endcase
  end

  assign lane_val = res_q[lane];
  assign acc_sum  = {1'b0, lane_val} + {1'b0, f_val};
  assign acc_val  = (SAT && acc_sum[XLEN]) ? XMAX : acc_sum[XLEN-1:0];

  logic [XLEN-1:0] rd_val;
  always_comb begin
    rd_val = '0;
    if (hit_a)         rd_val = a_q[abi];
    else if (hit_b)    rd_val = b_q[abi];
    else if (hit_res)  rd_val = res_q[resi];
    else if (hit_ctrl) rd_val = {{(XLEN-3){1'b0}}, mode_q, 1'b0};
    else if (hit_stat) rd_val = {{(XLEN-3){1'b0}}, err_q, busy, done_q};
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int k = 0; k < RES_NUM; k++) res_q[k] <= '0;
      mode_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q  <= rd;
      rdata_q <= rd ? rd_val : '0;
      if (err_set) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (wr && hit_a)    a_q[abi] <= wdata_i;
          if (wr && hit_b)    b_q[abi] <= wdata_i;
          if (wr && hit_ctrl) mode_q   <= wdata_i[2:1];
          if (start_acc) begin
            state_q <= RUN;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < RES_NUM; k++) res_q[k] <= '0;
          end
        end
        default: begin
          res_q[lane] <= acc_val;
          idx_q       <= idx_q + DW'(1);
          if (idx_q == LAST) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ack_o   = req_i;
  assign resp_o  = resp_q;
  assign rdata_o = rdata_q;
  assign irq_o   = done_q;

endmodule

// File: tb/tb_vec_accel.sv
// Bench for vec_accel: spec vector table, hand sequences for error/reset cases, random runs vs model.
module tb_vec_accel;
  localparam int XLEN = 32, DEPTH = 8, RES_NUM = 4, ADDR_W = 12;
  localparam logic [11:0] CTRL = 12'h050, STAT = 12'h054;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;
`ifdef VEC_ACCEL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn, req, we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic              ack, resp, irq;
  logic [XLEN-1:0]   rdata;

  always #5 clk = ~clk;

  vec_accel #(.XLEN(XLEN), .DEPTH(DEPTH), .RES_NUM(RES_NUM), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ack_o(ack), .resp_o(resp), .rdata_o(rdata), .irq_o(irq)
  );

  int tests = 0;
  int fails = 0;
  longint unsigned ma [DEPTH];
  longint unsigned mb [DEPTH];
  longint unsigned exp_res [RES_NUM];

  typedef struct { int mode; longint unsigned r [RES_NUM]; } mode_vec_t;
  typedef struct { logic [11:0] a; logic [31:0] e; string name; } rd_vec_t;
  mode_vec_t mtbl [4];
  rd_vec_t   rtbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk); req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1; req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk); req = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    check("resp", {63'd0, resp}, 64'd1);
    d = rdata; req = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] e);
    logic [31:0] d;
    bus_rd(a, d);
    check(name, {32'd0, d}, {32'd0, e});
  endtask

  task automatic load_mem();
    for (int i = 0; i < DEPTH; i++) bus_wr(12'(4 * i), ma[i][31:0]);
    for (int i = 0; i < DEPTH; i++) bus_wr(12'(4 * (DEPTH + i)), mb[i][31:0]);
  endtask

  task automatic load_spec();
    int sa [DEPTH] = '{1, 2, 3, 4, 8, 7, 6, 5};
    int sb [DEPTH] = '{7, 5, 3, 1, 4, 6, 8, 10};
    for (int i = 0; i < DEPTH; i++) begin ma[i] = longint'(sa[i]); mb[i] = longint'(sb[i]); end
    load_mem();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!irq && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic run(input int mode, output int n);
    bus_wr(CTRL, 32'((mode << 1) | 1));
    wait_done(n);
  endtask

  function automatic longint unsigned clampw(input longint unsigned v);
    if (SAT) return (v > MAXV) ? MAXV : v;
    return v & MAXV;
  endfunction

  function automatic longint unsigned fmod(input int mode, input longint unsigned a, input longint unsigned b);
    longint unsigned v;
    case (mode)
      0:       v = a + b;
      1:       v = a * b;
      2:       v = (a > b) ? a : b;
      default: v = (a > b) ? a - b : b - a;
    endcase
    return clampw(v);
  endfunction

  task automatic model(input int mode);
    for (int k = 0; k < RES_NUM; k++) exp_res[k] = 0;
    for (int i = 0; i < DEPTH; i++)
      exp_res[i % RES_NUM] = clampw(exp_res[i % RES_NUM] + fmod(mode, ma[i], mb[i]));
  endtask

  task automatic chk_res(input string tag, input longint unsigned e [RES_NUM]);
    for (int k = 0; k < RES_NUM; k++)
      rd_chk($sformatf("%s_res%0d", tag, k), 12'(4 * (2 * DEPTH + k)), e[k][31:0]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit quiet;
    longint unsigned z [RES_NUM];
    longint unsigned t20 [RES_NUM];

    mtbl[0].mode = 0; mtbl[0].r = '{20, 20, 20, 20};
    mtbl[1].mode = 1; mtbl[1].r = '{39, 52, 57, 54};
    mtbl[2].mode = 2; mtbl[2].r = '{15, 12, 11, 14};
    mtbl[3].mode = 3; mtbl[3].r = '{10, 4, 2, 8};
    rtbl[0] = '{12'h054, 32'd0, "rst_status"};
    rtbl[1] = '{12'h040, 32'd0, "rst_res0"};
    rtbl[2] = '{12'h04C, 32'd0, "rst_res3"};
    rtbl[3] = '{12'h000, 32'd0, "rst_a0"};
    rtbl[4] = '{12'h03C, 32'd0, "rst_b7"};
    rtbl[5] = '{12'h050, 32'd0, "rst_ctrl"};
    rtbl[6] = '{12'h05C, 32'd0, "rst_unmapped"};
    z = '{0, 0, 0, 0};
    t20 = '{20, 20, 20, 20};

    rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    check("rst_irq", {63'd0, irq}, 64'd0);
    check("rst_resp", {63'd0, resp}, 64'd0);
    req = 1'b1; #1;
    check("ack_follows_req", {63'd0, ack}, 64'd1);
    req = 1'b0; #1;
    check("ack_low", {63'd0, ack}, 64'd0);
    foreach (rtbl[i]) rd_chk(rtbl[i].name, rtbl[i].a, rtbl[i].e);

    // Reference scenarios from the mode table
    load_spec();
    foreach (mtbl[t]) begin
      run(mtbl[t].mode, n);
      check($sformatf("mode%0d_done_latency", mtbl[t].mode), 64'(n), 64'(DEPTH));
      chk_res($sformatf("mode%0d", mtbl[t].mode), mtbl[t].r);
      rd_chk($sformatf("mode%0d_status", mtbl[t].mode), STAT, 32'h1);
    end

    // Disturbances while busy: A write and restart both rejected
    bus_wr(CTRL, 32'h1);
    bus_wr(12'h000, 32'h99);
    bus_wr(CTRL, 32'h1);
    rd_chk("busy_err_status", STAT, 32'h6);
    wait_done(n);
    check("busy_run_done", {63'd0, irq}, 64'd1);
    rd_chk("busy_a0_kept", 12'h000, 32'h1);
    chk_res("busy", t20);
    rd_chk("busy_final_status", STAT, 32'h5);

    // Unmapped read and RES write
    run(0, n);
    rd_chk("clean_status", STAT, 32'h1);
    rd_chk("unmapped_read", 12'h05C, 32'h0);
    bus_wr(12'h040, 32'h1234);
    rd_chk("res_wr_err", STAT, 32'h5);
    rd_chk("res_wr_dropped", 12'h040, 32'd20);

    // Overflow boundary
    for (int i = 0; i < DEPTH; i++) begin ma[i] = 0; mb[i] = 0; end
    ma[0] = MAXV; mb[0] = 2;
    load_mem();
    run(0, n);
    rd_chk("ovf_res0", 12'h040, SAT ? 32'hFFFF_FFFF : 32'h1);
    rd_chk("ovf_res1", 12'h044, 32'h0);

    // Randomized runs against the model
    for (int it = 0; it < 16; it++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < DEPTH; i++) begin
        ma[i] = (it % 2 == 1) ? longint'($urandom) : longint'($urandom_range(0, 255));
        mb[i] = (it % 4 == 3) ? longint'($urandom) : longint'($urandom_range(0, 255));
      end
      load_mem();
      model(mode);
      run(mode, n);
      check($sformatf("rnd%0d_latency", it), 64'(n), 64'(DEPTH));
      chk_res($sformatf("rnd%0d_m%0d", it, mode), exp_res);
    end

    // Reset in the middle of a run
    load_spec();
    bus_wr(CTRL, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    @(posedge clk); #1;
    check("midrst_irq", {63'd0, irq}, 64'd0);
    @(negedge clk); rstn = 1'b1;
    rd_chk("midrst_status", STAT, 32'h0);
    chk_res("midrst", z);
    rd_chk("midrst_a0", 12'h000, 32'h0);
    rd_chk("midrst_b0", 12'h020, 32'h0);
    quiet = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (irq) quiet = 1'b0;
    end
    check("midrst_no_done", {63'd0, quiet}, 64'd1);
    load_spec();
    run(0, n);
    check("restart_latency", 64'(n), 64'(DEPTH));
    chk_res("restart", t20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vec_accel.md
VEC_ACCEL -- requirements
Module: vec_accel

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, which sets the element, accumulator and bus data width.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving elements per operand bank; it is a power of 2 and at least RES_NUM.
REQ-003 The block SHALL have parameter RES_NUM, default 4, giving the number of result lanes; it is a power of 2 and divides DEPTH.
REQ-004 The block SHALL have parameter ADDR_W, default 12, giving the byte-address width.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rstn_i, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port req_i, input, 1 bit: bus request.
REQ-008 The block SHALL have port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port addr_i, input, ADDR_W bits: byte address; bits [1:0] are ignored.
REQ-010 The block SHALL have port wdata_i, input, XLEN bits: write data.
REQ-011 The block SHALL have port ack_o, output, 1 bit: request accepted; combinationally equal to req_i (always ready).
REQ-012 The block SHALL have port resp_o, output, 1 bit: one-cycle pulse marking read data valid.
REQ-013 The block SHALL have port rdata_o, output, XLEN bits: read data, valid while resp_o = 1.
REQ-014 The block SHALL have port irq_o, output, 1 bit: level copy of STATUS.done.

Function
REQ-015 The word map SHALL be: A[i] at 4*i; B[i] at 4*(DEPTH+i); RES[k] at 4*(2*DEPTH+k); CTRL at 4*(2*DEPTH+RES_NUM); STATUS at the next word. With defaults this is A 0x00-0x1C, B 0x20-0x3C, RES 0x40-0x4C, CTRL 0x50, STATUS 0x54.
REQ-016 CTRL SHALL be laid out as: bit0 start (write-1 pulse, self-clearing, reads as 0); bits [2:1] mode (0 add, 1 mul low XLEN, 2 unsigned max, 3 unsigned absolute difference).
REQ-017 STATUS SHALL be read-only and laid out as: bit0 done, bit1 busy, bit2 err (sticky).
REQ-018 Reads SHALL return data with resp_o one cycle after acceptance; back-to-back requests SHALL be supported at one per cycle.
REQ-019 Reads of an unmapped address SHALL return 0; writes to an unmapped address, RES or STATUS SHALL be dropped and SHALL set err.
REQ-020 The state machine SHALL have states IDLE and RUN: IDLE goes to RUN on a start write; RUN goes to IDLE after the element with index DEPTH-1 has been processed.
REQ-021 On start in IDLE, the block SHALL clear all RES, done and err, set busy the next cycle, and reset index i to 0.
REQ-022 In RUN, the block SHALL process one element per cycle: RES[i mod RES_NUM] += f(A[i], B[i]), with arithmetic modulo 2^XLEN.
REQ-023 done SHALL assert and busy SHALL deassert exactly DEPTH+1 cycles after the cycle in which start was accepted.
REQ-024 A start write while busy SHALL be ignored and SHALL set err; the mode bits SHALL still be dropped, and the mode in use is latched at start.
REQ-025 Writes to A or B while busy SHALL be dropped and SHALL set err.
REQ-026 Reads of RES while busy SHALL return the current partial sums.
REQ-027 done SHALL remain set until the next accepted start.

Reset
REQ-028 When rstn_i = 0 at a clock edge, the block SHALL return to IDLE and clear all of the following to 0: A, B, RES, mode, done, busy, err, resp_o, rdata_o and irq_o.
REQ-029 Reset asserted mid-RUN SHALL abort the operation and leave no done indication.

Configuration
REQ-030 With macro VEC_ACCEL_SAT_EN defined, f results and accumulations SHALL saturate at 2^XLEN-1, unsigned.
REQ-031 Without VEC_ACCEL_SAT_EN, f results and accumulations SHALL wrap modulo 2^XLEN.

Verification
REQ-032 Mode 0 scenario: A=1,2,3,4,8,7,6,5 and B=7,5,3,1,4,6,8,10, then write CTRL=0x1 -> RES=20,20,20,20; done is read after 9 cycles.
REQ-033 Modes 1, 2 and 3 on the same data -> RES = 39,52,57,54 (mode 1); 15,12,11,14 (mode 2); 10,4,2,8 (mode 3).
REQ-034 While busy, write A[0]=0x99 and write CTRL=0x1 -> err=1, A[0] unchanged, results identical to the undisturbed run.
REQ-035 A[0]=0xFFFFFFFF, B[0]=2, all other elements 0, mode 0 -> RES[0]=0xFFFFFFFF when VEC_ACCEL_SAT_EN is defined, and RES[0]=1 when it is not.
REQ-036 Drop rstn_i at cycle 3 of RUN -> the next cycle STATUS=0, all RES=0 and A=0; a reload followed by a restart yields the correct results.
REQ-037 A read of 0x5C -> rdata_o=0 with resp_o; a write to 0x40 -> err=1 and RES[0] unchanged.
